// File: rtl/cpu_mem_arbiter.sv
`default_nettype none
// cpu_mem_arbiter: serialises split instruction/data CPU requests onto one memory port.
// Define ARB_RR_EN for round-robin tie-breaking; default build gives the data port fixed priority.
module cpu_mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_read,
  input  logic [31:0] inst_addr,
  output logic        inst_resp,
  output logic [31:0] inst_rdata,
  input  logic        data_read,
  input  logic        data_write,
  input  logic [3:0]  data_mbe,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_resp,
  output logic [31:0] data_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [3:0]  mem_mbe,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_resp,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t state;
  logic   data_req;
  logic   grant_data;

  assign data_req = data_read | data_write;

`ifdef ARB_RR_EN
  logic last_grant;  // 0 = inst, 1 = data
  assign grant_data = data_req & (~inst_read | ~last_grant);
`else
  // Data wins ties: the older instruction further down the pipeline must drain first.
  assign grant_data = data_req;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      inst_resp  <= 1'b0;
      data_resp  <= 1'b0;
      inst_rdata <= 32'h0;
      data_rdata <= 32'h0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_mbe    <= 4'h0;
      mem_addr   <= 32'h0;
      mem_wdata  <= 32'h0;
`ifdef ARB_RR_EN
      last_grant <= 1'b0;
`endif
    end else begin
      inst_resp <= 1'b0;
      data_resp <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_data) begin
            // A simultaneous read+write is illegal and is served as a write.
            mem_write <= data_write;
            mem_read  <= ~data_write;
            mem_addr  <= data_addr;
            mem_mbe   <= data_mbe;
            mem_wdata <= data_wdata;
            state     <= BUSY_D;
`ifdef ARB_RR_EN
            last_grant <= 1'b1;
`endif
          end else if (inst_read) begin
            mem_read  <= 1'b1;
            mem_write <= 1'b0;
            mem_addr  <= inst_addr;
            mem_mbe   <= 4'hF;
            state     <= BUSY_I;
`ifdef ARB_RR_EN
            last_grant <= 1'b0;
`endif
          end
        end
        BUSY_I: begin
          if (mem_resp) begin
            mem_read   <= 1'b0;
            inst_rdata <= mem_rdata;
            inst_resp  <= 1'b1;
            state      <= DONE;
          end
        end
        BUSY_D: begin
          if (mem_resp) begin
            if (mem_read) data_rdata <= mem_rdata;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            data_resp <= 1'b1;
            state     <= DONE;
          end
        end
        // The requester still holds its request here, so no grant is made.
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/cpu_mem_arbiter.md
# cpu_mem_arbiter

Responder for the CPU's split instruction/data memory ports. It accepts fetches on the instruction port and loads/stores on the data port, and serialises them onto a single downstream memory port (`mem_*`). It returns read data and a one-cycle `*_resp` pulse to the pipeline. It sits between the `cpu` top level and the shared cache/memory.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `inst_read`  in  1  fetch request; held by the CPU until `inst_resp`.
- `inst_addr`  in  32  fetch address.
- `inst_resp`  out  1  fetch complete, one-cycle pulse.
- `inst_rdata`  out  32  fetch data; valid while `inst_resp` is high.
- `data_read`  in  1  load request; held until `data_resp`.
- `data_write`  in  1  store request; held until `data_resp`.
- `data_mbe`  in  4  store byte enables.
- `data_addr`  in  32  load/store address.
- `data_wdata`  in  32  store data.
- `data_resp`  out  1  load/store complete, one-cycle pulse.
- `data_rdata`  out  32  load data; valid while `data_resp` is high.
- `mem_read`  out  1  downstream read; held until `mem_resp`.
- `mem_write`  out  1  downstream write; held until `mem_resp`.
- `mem_mbe`  out  4  downstream byte enables.
- `mem_addr`  out  32  downstream address.
- `mem_wdata`  out  32  downstream write data.
- `mem_resp`  in  1  downstream completion.
- `mem_rdata`  in  32  downstream read data; valid with `mem_resp`.

## Operation
States: IDLE, BUSY_I, BUSY_D, DONE.

- **IDLE:** no `mem_*` request driven.
  - Data request only -> latch `data_addr`, `data_mbe`, `data_wdata` and the op -> BUSY_D.
  - `inst_read` only -> latch `inst_addr` -> BUSY_I.
  - Both pending -> arbitrate (see Configuration).
  - Neither -> stay in IDLE.
- **BUSY_I:**
  - Drive `mem_read=1`, `mem_addr` = latched address, `mem_write=0`, `mem_mbe=4'hF`.
  - On `mem_resp`: register `mem_rdata` into `inst_rdata`, set `inst_resp` for the next cycle -> DONE.
- **BUSY_D:**
  - Drive `mem_read` or `mem_write` from the latched op, plus the latched address, mbe and wdata.
  - On `mem_resp`: set `data_resp` for the next cycle; register `mem_rdata` into `data_rdata` only for reads -> DONE.
- **DONE:**
  - The completing `*_resp` is high for exactly this cycle.
  - No grant is made, because the CPU's request is still asserted this cycle.
  - Next state is IDLE.
- Latched request registers are frozen for the whole transaction. CPU input changes during BUSY are ignored.
- `data_read` and `data_write` both high is illegal. The arbiter treats it as a write.
- `mem_resp` in IDLE or DONE is ignored.
- `mem_read` and `mem_write` are never both high.
- `inst_rdata` and `data_rdata` hold their last captured value between responses.

## Timing
- Reset values:
  - State is IDLE.
  - `inst_resp`, `data_resp`, `mem_read`, `mem_write` are 0.
  - `mem_mbe`, `mem_addr`, `mem_wdata`, `inst_rdata`, `data_rdata` are 0.
- Request sampled at cycle 0 (IDLE) -> `mem_*` asserted from cycle 1.
- `mem_resp` at cycle k (k ≥ 1) -> `*_resp` high at cycle k+1 (DONE) -> IDLE at k+2.
- Minimum turnaround is 3 cycles per transaction.
- Back-to-back requests:
  - A request still pending in the IDLE cycle at k+2 is granted there.
  - Its downstream request starts at k+3.
- `mem_*` outputs are decoded from registered state only. There is no combinational path from CPU inputs to `mem_*` or from `mem_resp` to `*_resp`.
- Reset mid-transaction:
  - `mem_read`/`mem_write` drop immediately (asynchronously) and no `*_resp` is issued.
  - A `mem_resp` arriving after reset release is ignored.

## Configuration
- `ARB_RR_EN` undefined: fixed priority. On simultaneous requests, the data port always wins, since the older instruction further down the pipeline must drain first.
- `ARB_RR_EN` defined: round-robin.
  - A `last_grant` flop is updated on every grant; its reset value is `inst`.
  - On simultaneous requests in IDLE, the port not granted last wins, so the first tie after reset goes to data.
  - Single-requester behaviour is identical to fixed priority.

## Test plan
- Fetch at `inst_addr=0x60` with memory responding 2 cycles after `mem_read` and data `0x00500093`:
  - `mem_read=1`, `mem_addr=0x60` from cycle 1.
  - `inst_resp=1` for one cycle at cycle 4 with `inst_rdata=0x00500093`.
  - No `mem_read` in the DONE cycle.
- Store `data_addr=0x100`, `data_mbe=4'b0011`, `data_wdata=0xDEADBEEF`, with immediate `mem_resp`:
  - `mem_write=1` with matching mbe/addr/wdata for exactly 1 cycle.
  - `data_resp` pulse at cycle 2.
  - `data_rdata` unchanged.
- Simultaneous `inst_read` (0x64) and `data_read` (0x200), both held:
  - Without the macro: data served first, then the instruction.
  - With `ARB_RR_EN`: first tie goes to data; a second tie goes to the instruction.
- Load whose `data_addr` toggles during BUSY_D:
  - `mem_addr` stays at the latched value.
  - Returned data arrives with a single `data_resp`.
- `rst` asserted while `mem_read` is high in BUSY_I:
  - All outputs go to 0 asynchronously.
  - A `mem_resp` after release produces no `inst_resp`.
- CPU holds `inst_read` through DONE: exactly one `inst_resp` per transaction and a new grant in the following IDLE cycle.
